// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer for the execute stage.
// One operation at a time: radix-2 shift-add multiply or restoring shift-subtract divide,
// WIDTH iterations, then a one-cycle result strobe. Divide-by-zero and signed overflow
// bypass the iterations and finish the cycle after start.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   start_i          M-op present in execute (level, held while stall_o=1)
//   funct3_i         0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//   op1_i, op2_i     rs1 / rs2 values
//   flush_i          abort the current operation
//   stall_o          stall request to the pipeline controller
//   result_o         result, valid only while result_valid_o=1
//   result_valid_o   one-cycle result strobe
//   busy_o           sequencer not idle
`timescale 1ns/1ps

module muldiv_seq #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [2:0]       funct3_i,
  input  logic [WIDTH-1:0] op1_i,
  input  logic [WIDTH-1:0] op2_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic [WIDTH-1:0] result_o,
  output logic             result_valid_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e               state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [2:0]           op_q;
  logic                 neg_q;
  // Multiply: {partial product high, multiplier being shifted out}.
  // Divide:   {partial remainder, dividend shifting out / quotient shifting in}.
  logic [2*WIDTH-1:0]   acc_q;
  logic [WIDTH-1:0]     opb_q;  // multiplicand or divisor magnitude
  logic [WIDTH-1:0]     result_q;
  logic                 valid_q;

  // Start-time decode
  logic             signed1, signed2, sign1, sign2, neg_start;
  logic [WIDTH-1:0] mag1, mag2;
  logic             div_zero, div_ovf;
  logic [WIDTH-1:0] special_val;

  always_comb begin
    signed1   = (funct3_i == 3'd1) | (funct3_i == 3'd2) | (funct3_i == 3'd4) |
                (funct3_i == 3'd6);
    signed2   = (funct3_i == 3'd1) | (funct3_i == 3'd4) | (funct3_i == 3'd6);
    sign1     = signed1 & op1_i[WIDTH-1];
    sign2     = signed2 & op2_i[WIDTH-1];
    mag1      = sign1 ? -op1_i : op1_i;
    mag2      = sign2 ? -op2_i : op2_i;
    // Remainder takes the dividend's sign; everything else the XOR of both.
    neg_start = (funct3_i == 3'd6) ? sign1 : (sign1 ^ sign2);
    div_zero  = funct3_i[2] & (op2_i == '0);
    div_ovf   = funct3_i[2] & ~funct3_i[0] & (op1_i == {1'b1, {(WIDTH-1){1'b0}}}) &
                (op2_i == '1);
    // funct3[1] separates REM/REMU from DIV/DIVU
    if (funct3_i[1]) special_val = div_zero ? op1_i : '0;
    else             special_val = div_zero ? '1 : op1_i;
  end

  // One iteration step and final result selection
  logic [WIDTH:0]       mul_sum, div_trial;
  logic [2*WIDTH-1:0]   acc_step, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix, final_val;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opb_q};
    div_trial = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, opb_q};
    if (op_q[2]) begin
      // Borrow out of the trial subtraction means restore (keep the shifted remainder).
      acc_step = div_trial[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                  : {div_trial[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
    end
    prod_fix = neg_q ? -acc_step : acc_step;
    quo_fix  = neg_q ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
    rem_fix  = neg_q ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
    if (op_q[2])               final_val = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'd0) final_val = prod_fix[WIDTH-1:0];
    else                       final_val = prod_fix[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else if (flush_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          valid_q <= 1'b0;
          if (start_i) begin
            op_q  <= funct3_i;
            neg_q <= neg_start;
            cnt_q <= '0;
            if (div_zero | div_ovf) begin
              result_q <= special_val;
              valid_q  <= 1'b1;
              state_q  <= StDone;
            end else begin
              acc_q   <= {{WIDTH{1'b0}}, (funct3_i[2] ? mag1 : mag2)};
              opb_q   <= funct3_i[2] ? mag2 : mag1;
              state_q <= StBusy;
            end
          end
        end
        StBusy: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            result_q <= final_val;
            valid_q  <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          valid_q <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // The pipeline advances in the DONE cycle, so the stall drops there.
  assign stall_o        = start_i & (state_q != StDone) & ~flush_i;
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps

module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op1, op2;
  logic        stall_o, result_valid_o, busy_o;
  logic [31:0] result_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.WIDTH(32), .CNT_W(6)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .start_i        (start),
    .funct3_i       (funct3),
    .op1_i          (op1),
    .op2_i          (op2),
    .flush_i        (flush),
    .stall_o        (stall_o),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .busy_o         (busy_o)
  );

  // RV32M semantics with plain 64-bit arithmetic.
  function automatic logic [31:0] model_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'd0: begin up = ua * ub; r = up; return r[31:0]; end
      3'd1: begin sp = sa * sb; r = sp; return r[63:32]; end
      3'd2: begin sp = sa * longint'(ub); r = sp; return r[63:32]; end
      3'd3: begin up = ua * ub; r = up; return r[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        sp = sa / sb; r = sp; return r[31:0];
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        sp = sa % sb; r = sp; return r[31:0];
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    if (f[2] && b == 32'd0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Called at posedge+1 of an idle cycle (cycle 0). Returns at the negedge of the strobe
  // cycle with start still high; lat = -1 if no strobe within the budget.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat, output int stl);
    start = 1'b1; funct3 = f; op1 = a; op2 = b;
    lat = -1; stl = 0; res = 'x;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (stall_o) stl++;
      if (result_valid_o) begin
        lat = k; res = result_o;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic gap();
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; flush = 1'b0; funct3 = '0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    n_vec++; if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", result_valid_o); end
    n_vec++; if (result_o !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h expected 0", result_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, stl;
    do_op(3'd0, 32'd7, 32'd6, r, lat, stl);
    n_vec++; if (r !== 32'd42) begin n_err++; $display("FAIL mul_7x6: got %h expected %h", r, 32'd42); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    n_vec++; if (stl !== 33) begin n_err++; $display("FAIL mul_stall_cycles: got %0d expected 33", stl); end
    gap();
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat, stl;
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, r, lat, stl);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mulh: got %h expected ffffffff", r); end
    gap();
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, r, lat, stl);
    n_vec++; if (r !== 32'h0000_0001) begin n_err++; $display("FAIL mulhu: got %h expected 00000001", r); end
    gap();
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, stl;
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, r, lat, stl);
    n_vec++; if (r !== 32'hFFFF_FFFD) begin n_err++; $display("FAIL div_neg7_2: got %h expected fffffffd", r); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL div_latency: got %0d expected 33", lat); end
    gap();
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, r, lat, stl);
    n_vec++; if (r !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rem_neg7_2: got %h expected ffffffff", r); end
    gap();
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, r, lat, stl);
    n_vec++; if (r !== 32'h7FFF_FFFC) begin n_err++; $display("FAIL divu_neg7_2: got %h expected 7ffffffc", r); end
    gap();
  endtask

  task automatic test_special();
    logic [2:0]  f [4] = '{3'd5, 3'd6, 3'd4, 3'd6};
    logic [31:0] a [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] e [4] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] r; int lat, stl;
    for (int i = 0; i < 4; i++) begin
      do_op(f[i], a[i], b[i], r, lat, stl);
      n_vec++; if (r !== e[i]) begin n_err++; $display("FAIL special_%0d: got %h expected %h", i, r, e[i]); end
      n_vec++; if (lat !== 1) begin n_err++; $display("FAIL special_%0d_latency: got %0d expected 1", i, lat); end
      gap();
    end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat, stl; bit seen;
    seen = 1'b0;
    start = 1'b1; funct3 = 3'd4; op1 = 32'd100; op2 = 32'd7;
    for (int k = 0; k <= 10; k++) begin
      if (k == 10) flush = 1'b1;
      @(negedge clk);
      if (result_valid_o) seen = 1'b1;
      if (k == 10) begin
        n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
      end
      @(posedge clk); #1;
    end
    flush = 1'b0;
    do_op(3'd0, 32'd3, 32'd3, r, lat, stl);
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL flush_no_strobe: got %b expected 0", seen); end
    n_vec++; if (r !== 32'd9) begin n_err++; $display("FAIL flush_then_mul: got %h expected 9", r); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL flush_then_mul_latency: got %0d expected 33", lat); end
    gap();
  endtask

  task automatic test_flush_idle();
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op1 = 32'd5; op2 = 32'd5;
    @(negedge clk);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_stall: got %b expected 0", stall_o); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_idle_busy: got %b expected 0", busy_o); end
    gap();
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, stl;
    do_op(3'd0, 32'd2, 32'd3, r, lat, stl);
    n_vec++; if (r !== 32'd6) begin n_err++; $display("FAIL b2b_first: got %h expected 6", r); end
    @(posedge clk); #1;  // IDLE cycle right after DONE, start still high
    do_op(3'd0, 32'd4, 32'd5, r, lat, stl);
    n_vec++; if (r !== 32'd20) begin n_err++; $display("FAIL b2b_second: got %h expected 20", r); end
    n_vec++; if (lat !== 33) begin n_err++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
    gap();
  endtask

  task automatic test_reset_mid();
    start = 1'b1; funct3 = 3'd0; op1 = 32'd9; op2 = 32'd9;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_vec++; if (stall_o !== 1'b0) begin n_err++; $display("FAIL midrst_stall: got %b expected 0", stall_o); end
    n_vec++; if (result_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b expected 0", result_valid_o); end
    n_vec++; if (result_o !== 32'd0) begin n_err++; $display("FAIL midrst_result: got %h expected 0", result_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %b expected 0", busy_o); end
    gap();
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    logic [2:0] f; logic [31:0] a, b, r, e; int lat, stl, el;
    for (int i = 0; i < 60; i++) begin
      f  = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      e  = model_result(f, a, b);
      el = model_latency(f, a, b);
      do_op(f, a, b, r, lat, stl);
      n_vec++;
      if (r !== e) begin
        n_err++;
        $display("FAIL rand_%0d f=%0d a=%h b=%h: got %h expected %h", i, f, a, b, r, e);
      end
      n_vec++;
      if (lat !== el || stl !== el) begin
        n_err++;
        $display("FAIL rand_%0d_timing: got lat=%0d stall=%0d expected %0d", i, lat, stl, el);
      end
      if ($urandom_range(0, 1) == 0) gap();
      else begin @(posedge clk); #1; end
    end
    gap();
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
